mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_if.sv | 21 ++
 rtl/mem_responder.sv | 106 ++++++++++
 tb/tb_mem_responder.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/response bus between a core memory port and mem_responder.
interface mem_responder_if;
   logic        mem_req;
   logic [63:0] mem_addr;
   logic        mem_wen;
   logic [7:0]  mem_strb;
   logic [63:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_err;
   logic [63:0] mem_rdata;

   modport master (
      output mem_req, mem_addr, mem_wen, mem_strb, mem_wdata,
      input  mem_gnt, mem_err, mem_rdata
   );

   modport slave (
      input  mem_req, mem_addr, mem_wen, mem_strb, mem_wdata,
      output mem_gnt, mem_err, mem_rdata
   );
endinterface

// File: rtl/mem_responder.sv
// Memory responder with LFSR-driven random wait states in front of a byte-strobed store.
// Define MEM_RESPONDER_ERR_EN to flag out-of-range accesses on mem_err.
module mem_responder #(
   parameter int unsigned DEPTH     = 64,
   parameter int unsigned MAX_STALL = 3,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic g_clk,
   input  logic g_reset,
   mem_responder_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t          state, state_nxt;
   logic [3:0]      cnt, cnt_nxt;
   logic [3:0]      stall_load;
   logic [15:0]     lfsr;
   logic            gnt;
   logic            in_range;
   logic [AW-1:0]   idx;
   logic [63:0]     rdata_q;
   logic [63:0]     store [DEPTH];
   logic            unused_addr_bits;

   assign stall_load       = 4'(32'(lfsr[3:0]) % (MAX_STALL + 1));
   assign in_range         = (bus.mem_addr[63:AW+3] == '0);
   assign idx              = bus.mem_addr[AW+2:3];
   assign unused_addr_bits = ^bus.mem_addr[2:0];

   assign gnt           = (state == WAIT) && (cnt == '0) && bus.mem_req;
   assign bus.mem_gnt   = gnt;
   assign bus.mem_rdata = rdata_q;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      unique case (state)
         IDLE: begin
            if (bus.mem_req) begin
               state_nxt = WAIT;
               cnt_nxt   = stall_load;
            end
         end
         WAIT: begin
            if (!bus.mem_req) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (cnt == '0) begin
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Fibonacci LFSR, taps 16,14,13,11
   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         state <= IDLE;
         cnt   <= '0;
         lfsr  <= LFSR_SEED;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         lfsr  <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      end
   end

   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         rdata_q <= '0;
      end else if (gnt) begin
         if (!bus.mem_wen && in_range) rdata_q <= store[idx];
         else                          rdata_q <= '0;
      end
   end

`ifdef MEM_RESPONDER_ERR_EN
   logic err_q;

   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset)  err_q <= 1'b0;
      else if (gnt) err_q <= !in_range;
   end

   assign bus.mem_err = err_q;
`else
   assign bus.mem_err = 1'b0;
`endif

   // Store has no reset; the g_reset term blocks a write on an edge coinciding with reset.
   always_ff @(posedge g_clk) begin
      if (gnt && !g_reset && bus.mem_wen && in_range) begin
         for (int unsigned b = 0; b < 8; b++) begin
            if (bus.mem_strb[b]) store[idx][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
         end
      end
   end
endmodule

// File: tb/tb_mem_responder.sv
// Directed and randomized checks of mem_responder at MAX_STALL=0 and MAX_STALL=3.
module tb_mem_responder;
   logic g_clk = 1'b0;
   logic g_reset;
   int   checks = 0;
   int   errors = 0;

   logic [63:0] mdl [64];
   logic [3:0]  lat_seen = '0;

   always #5 g_clk = ~g_clk;

   mem_responder_if b0();
   mem_responder_if b3();

   mem_responder #(.MAX_STALL(0)) dut0 (.g_clk(g_clk), .g_reset(g_reset), .bus(b0));
   mem_responder #(.MAX_STALL(3)) dut3 (.g_clk(g_clk), .g_reset(g_reset), .bus(b3));

`ifdef MEM_RESPONDER_ERR_EN
   localparam logic OOR_ERR = 1'b1;
`else
   localparam logic OOR_ERR = 1'b0;
`endif

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One request on dut3; returns the cycle index (from first req cycle) of the grant.
   // Ends at the negedge of the cycle after the grant, when rdata/err are valid.
   task automatic access(input logic wen, input logic [63:0] addr, input logic [7:0] strb,
                         input logic [63:0] wdata, output int lat);
      @(posedge g_clk); #1;
      b3.mem_req   = 1'b1;
      b3.mem_wen   = wen;
      b3.mem_addr  = addr;
      b3.mem_strb  = strb;
      b3.mem_wdata = wdata;
      lat = 0;
      @(negedge g_clk);
      while (b3.mem_gnt !== 1'b1 && lat < 20) begin
         @(negedge g_clk);
         lat++;
      end
      @(posedge g_clk); #1;
      b3.mem_req = 1'b0;
      b3.mem_wen = 1'b0;
      @(negedge g_clk);
      chk("grant_latency_1_to_4", 64'(lat >= 1 && lat <= 4), 64'd1);
      if (lat >= 1 && lat <= 4) lat_seen[lat-1] = 1'b1;
   endtask

   initial begin
      int lat;
      int unsigned idx;
      logic        wen;
      logic [7:0]  strb;
      logic [63:0] data;
      logic [63:0] addr;
      logic [2:0]  lo;

      g_reset = 1'b1;
      b0.mem_req = 1'b0; b0.mem_wen = 1'b0; b0.mem_addr = '0; b0.mem_strb = '0; b0.mem_wdata = '0;
      b3.mem_req = 1'b0; b3.mem_wen = 1'b0; b3.mem_addr = '0; b3.mem_strb = '0; b3.mem_wdata = '0;
      repeat (2) @(posedge g_clk);
      @(negedge g_clk);
      chk("reset_gnt3",   64'(b3.mem_gnt), 64'd0);
      chk("reset_err3",   64'(b3.mem_err), 64'd0);
      chk("reset_rdata3", b3.mem_rdata,    64'd0);
      chk("reset_gnt0",   64'(b0.mem_gnt), 64'd0);
      @(posedge g_clk); #1;
      g_reset = 1'b0;

      // MAX_STALL=0: request held -> grants in cycles 1 and 3
      b0.mem_req = 1'b1; b0.mem_wen = 1'b1; b0.mem_addr = 64'h0; b0.mem_strb = 8'hFF;
      b0.mem_wdata = 64'h5;
      @(negedge g_clk);
      chk("s0_cycle0_gnt", 64'(b0.mem_gnt), 64'd0);
      @(posedge g_clk); #1; @(negedge g_clk);
      chk("s0_cycle1_gnt", 64'(b0.mem_gnt), 64'd1);
      @(posedge g_clk); #1; @(negedge g_clk);
      chk("s0_cycle2_gnt",   64'(b0.mem_gnt), 64'd0);
      chk("s0_write_rdata",  b0.mem_rdata,    64'd0);
      chk("s0_write_err",    64'(b0.mem_err), 64'd0);
      @(posedge g_clk); #1; @(negedge g_clk);
      chk("s0_cycle3_gnt", 64'(b0.mem_gnt), 64'd1);
      @(posedge g_clk); #1;
      b0.mem_wen = 1'b0;
      @(negedge g_clk);
      chk("s0_cycle4_gnt", 64'(b0.mem_gnt), 64'd0);
      @(posedge g_clk); #1; @(negedge g_clk);
      chk("s0_cycle5_gnt", 64'(b0.mem_gnt), 64'd1);
      @(posedge g_clk); #1;
      b0.mem_req = 1'b0;
      @(negedge g_clk);
      chk("s0_read_rdata", b0.mem_rdata,    64'h5);
      chk("s0_idle_gnt",   64'(b0.mem_gnt), 64'd0);

      // Full and partial strobe writes
      access(1'b1, 64'h10, 8'hFF, 64'h1122334455667788, lat);
      chk("wr10_rdata", b3.mem_rdata, 64'd0);
      access(1'b0, 64'h10, 8'h00, 64'd0, lat);
      chk("rd10_rdata", b3.mem_rdata,    64'h1122334455667788);
      chk("rd10_err",   64'(b3.mem_err), 64'd0);
      access(1'b1, 64'h10, 8'h0F, 64'hAAAAAAAAAAAAAAAA, lat);
      access(1'b0, 64'h10, 8'h00, 64'd0, lat);
      chk("rd10_strb0F", b3.mem_rdata, 64'h11223344AAAAAAAA);
      access(1'b0, 64'h17, 8'h00, 64'd0, lat);
      chk("rd17_low_bits_ignored", b3.mem_rdata, 64'h11223344AAAAAAAA);

      // Top word and out-of-range aliasing onto word 0
      access(1'b1, 64'h1F8, 8'hFF, 64'hDEADBEEFCAFEF00D, lat);
      access(1'b1, 64'h0,   8'hFF, 64'h0123456789ABCDEF, lat);
      access(1'b0, 64'h1F8, 8'h00, 64'd0, lat);
      chk("rd1F8_top", b3.mem_rdata, 64'hDEADBEEFCAFEF00D);
      access(1'b0, 64'h200, 8'h00, 64'd0, lat);
      chk("rd200_err",   64'(b3.mem_err), 64'(OOR_ERR));
      chk("rd200_rdata", b3.mem_rdata,    64'd0);
      access(1'b1, 64'h200, 8'hFF, 64'h9999999999999999, lat);
      chk("wr200_err", 64'(b3.mem_err), 64'(OOR_ERR));
      access(1'b0, 64'h0, 8'h00, 64'd0, lat);
      chk("rd0_no_alias", b3.mem_rdata,    64'h0123456789ABCDEF);
      chk("rd0_err",      64'(b3.mem_err), 64'd0);

      // Request withdrawn in WAIT: no access, outputs held
      access(1'b1, 64'h08, 8'hFF, 64'h5A5A5A5A0F0F0F0F, lat);
      access(1'b0, 64'h08, 8'h00, 64'd0, lat);
      chk("rd08_pre", b3.mem_rdata, 64'h5A5A5A5A0F0F0F0F);
      @(posedge g_clk); #1;
      b3.mem_req = 1'b1; b3.mem_wen = 1'b1; b3.mem_addr = 64'h08; b3.mem_strb = 8'hFF;
      b3.mem_wdata = 64'hFFFFFFFFFFFFFFFF;
      @(negedge g_clk);
      chk("drop_cycle0_gnt", 64'(b3.mem_gnt), 64'd0);
      @(posedge g_clk); #1;
      b3.mem_req = 1'b0; b3.mem_wen = 1'b0;
      @(negedge g_clk);
      chk("drop_gnt",   64'(b3.mem_gnt), 64'd0);
      @(posedge g_clk); #1; @(negedge g_clk);
      chk("drop_rdata", b3.mem_rdata,    64'h5A5A5A5A0F0F0F0F);
      access(1'b0, 64'h08, 8'h00, 64'd0, lat);
      chk("rd08_after_drop", b3.mem_rdata, 64'h5A5A5A5A0F0F0F0F);

      // Reset while a write waits in WAIT
      @(posedge g_clk); #1;
      b3.mem_req = 1'b1; b3.mem_wen = 1'b1; b3.mem_addr = 64'h08; b3.mem_strb = 8'hFF;
      b3.mem_wdata = 64'h7777777777777777;
      @(posedge g_clk); #1;
      g_reset = 1'b1;
      @(negedge g_clk);
      chk("rst_wait_gnt",   64'(b3.mem_gnt), 64'd0);
      chk("rst_wait_rdata", b3.mem_rdata,    64'd0);
      @(posedge g_clk); #1;
      g_reset = 1'b0;
      b3.mem_req = 1'b0; b3.mem_wen = 1'b0;
      access(1'b0, 64'h08, 8'h00, 64'd0, lat);
      chk("rd08_after_reset", b3.mem_rdata, 64'h5A5A5A5A0F0F0F0F);

      // Randomized traffic against a reference store
      for (int i = 0; i < 64; i++) begin
         data   = {$urandom, $urandom};
         mdl[i] = data;
         access(1'b1, 64'(i) << 3, 8'hFF, data, lat);
      end
      for (int n = 0; n < 1000; n++) begin
         idx  = $urandom_range(0, 63);
         wen  = 1'($urandom);
         strb = 8'($urandom);
         lo   = 3'($urandom);
         data = {$urandom, $urandom};
         addr = {55'd0, 6'(idx), lo};
         access(wen, addr, strb, data, lat);
         if (wen) begin
            for (int b = 0; b < 8; b++) begin
               if (strb[b]) mdl[idx][8*b +: 8] = data[8*b +: 8];
            end
            chk("rand_write_rdata", b3.mem_rdata, 64'd0);
         end else begin
            chk("rand_read_rdata", b3.mem_rdata, mdl[idx]);
         end
      end
      chk("all_latencies_seen", 64'(lat_seen), 64'hF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
